// File: rtl/decomp_pkg.sv
// Shared types for the stream decompressor: header tags, FSM states and
// the location of the tag field inside a compressed word.
package decomp_pkg;

  // Two-bit tag in the top bits of every header word.
  typedef enum logic [1:0] {
    TAG_LIT  = 2'b00,
    TAG_REP  = 2'b01,
    TAG_RSV2 = 2'b10,
    TAG_RSV3 = 2'b11
  } tag_e;

  typedef enum logic [1:0] {
    S_HDR,
    S_LIT,
    S_REP
  } state_e;

  localparam int TAG_W = 2;

  // The tag occupies the TAG_W most significant bits of a word.
  function automatic int tag_lsb(input int data_w);
    return data_w - TAG_W;
  endfunction

endpackage

// File: rtl/decomp_out_reg.sv
// Single-entry valid/ready holding register for raw samples. The owner
// asserts load only while free is high; a load in the same cycle as a
// downstream handshake replaces the leaving sample.
module decomp_out_reg #(
  parameter int DATA_W = 48
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              free
);

  assign free = !valid_out || ready_out;

  // Slot occupancy and payload; a load wins over a downstream handshake.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= load_data;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_decompressor.sv
// Rebuilds the raw sample stream from LITERAL / REPEAT coded memory words.
// Consumes words on the mem_valid/mem_ready handshake and presents samples
// through a single-entry output register with valid/ready backpressure.
module stream_decompressor
  import decomp_pkg::*;
#(
  parameter  int DATA_BYTES = 6,
  parameter  int COUNT_W    = 32,
  localparam int DATA_W     = DATA_BYTES * 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               mem_valid,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               mem_ready,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  input  logic               ready_out,
  output logic               err,
  output logic [COUNT_W-1:0] out_count
);

  localparam int TAG_LSB = tag_lsb(DATA_W);

  state_e             state;
  logic               have_lit;
  logic [COUNT_W-1:0] rep_cnt;
  logic [DATA_W-1:0]  last_sample;

  tag_e               tag;
  logic [COUNT_W-1:0] rep_len;
  logic               mem_fire;
  logic               out_fire;
  logic               free;
  logic               load;
  logic [DATA_W-1:0]  load_data;

  assign tag      = tag_e'(mem_data[TAG_LSB +: TAG_W]);
  assign rep_len  = mem_data[COUNT_W-1:0];
  assign mem_fire = mem_valid && mem_ready;
  assign out_fire = valid_out && ready_out;

  // Word acceptance depends only on state and the output slot, never on mem_valid.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    mem_ready = 1'b0;
    case (state)
      S_HDR:   mem_ready = 1'b1;
      S_LIT:   mem_ready = free;
      default: mem_ready = 1'b0;
    endcase
  end

  // Select what enters the output slot: a fresh literal or a repeat of the last one.
  always_comb begin
    load      = 1'b0;
    load_data = last_sample;
    case (state)
      S_LIT: begin
        load      = mem_fire;
        load_data = mem_data;
      end
      S_REP:   load = free;
      default: load = 1'b0;
    endcase
  end

  decomp_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .free      (free)
  );

  // Decode FSM: header parsing, literal capture, repeat countdown, sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HDR;
      have_lit    <= 1'b0;
      rep_cnt     <= '0;
      last_sample <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          if (mem_fire) begin
            case (tag)
              TAG_LIT: state <= S_LIT;
              TAG_REP: begin
                // A repeat with nothing to repeat is a protocol error even if N=0.
                if (!have_lit) begin
                  err <= 1'b1;
                end else if (rep_len != '0) begin
                  rep_cnt <= rep_len;
                  state   <= S_REP;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_LIT: begin
          if (mem_fire) begin
            last_sample <= mem_data;
            have_lit    <= 1'b1;
            state       <= S_HDR;
          end
        end
        S_REP: begin
          if (free) begin
            rep_cnt <= rep_cnt - 1'b1;
            if (rep_cnt == COUNT_W'(1)) state <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

  // Count samples leaving downstream; wraps naturally at 2^COUNT_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_count <= '0;
    else if (out_fire) out_count <= out_count + 1'b1;
  end

endmodule

// File: tb/tb_stream_decompressor.sv
// Self-checking bench for stream_decompressor. A reference model expands the
// word stream into the expected sample list; a per-cycle driver/monitor
// compares every leaving sample, stall stability and repeat-phase mem_ready.
module tb_stream_decompressor;

  localparam int DW = 48;
  localparam int CW = 32;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data  = '0;
  logic          ready_out = 1'b0;
  logic          mem_ready;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          err;
  logic [CW-1:0] out_count;

  stream_decompressor #(.DATA_BYTES(6), .COUNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_out (ready_out),
    .err       (err),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    int            id;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] wq[$];
  int            checks = 0;
  int            errors = 0;

  // Reference model state
  bit            m_have_lit;
  bit            m_expect_lit;
  bit            m_err;
  logic [DW-1:0] m_last;
  logic [CW-1:0] m_count;
  int            rep_seq;
  int            cur_rep;
  int            rep_guard;
  bit            rep_first;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  bit            lit_chk;
  logic [DW-1:0] lit_val;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [1:0] t, input logic [CW-1:0] n);
    logic [13:0] pad;
    pad = 14'($urandom);
    return {t, pad, n};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_have_lit   = 0;
    m_expect_lit = 0;
    m_err        = 0;
    m_last       = '0;
    m_count      = '0;
    rep_guard    = 0;
    rep_first    = 0;
    prev_stall   = 0;
    lit_chk      = 0;
  endtask

  // Apply the decoding rules to one accepted word and extend the expected list.
  task automatic model_accept(input logic [DW-1:0] w);
    logic [1:0]    t;
    logic [CW-1:0] n;
    t = w[DW-1 -: 2];
    n = w[CW-1:0];
    if (m_expect_lit) begin
      m_expect_lit = 0;
      m_last       = w;
      m_have_lit   = 1;
      exp_q.push_back('{data: w, id: 0});
      lit_chk = 1;
      lit_val = w;
    end else begin
      case (t)
        2'b00: m_expect_lit = 1;
        2'b01: begin
          if (!m_have_lit) m_err = 1;
          else if (n != 0) begin
            rep_seq++;
            cur_rep   = rep_seq;
            rep_guard = int'(n) - 1;
            rep_first = 1;
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{data: m_last, id: rep_seq});
          end
        end
        default: m_err = 1;
      endcase
    end
  endtask

  // Drive wq cycle by cycle. ready_pct<0 selects the 1,0,0 ready pattern.
  // stop_at>=0 returns once that many samples have left (mid-stream).
  task automatic run_stream(input int ready_pct, input int stop_at, input int budget);
    int idx  = 0;
    int dep  = 0;
    int cyc  = 0;
    int idle = 0;
    bit done = 0;
    while (!done && cyc < budget) begin
      @(negedge clock);
      if (ready_pct < 0) ready_out = (cyc % 3 == 0);
      else               ready_out = ($urandom_range(99) < ready_pct);
      mem_valid = (idx < wq.size());
      mem_data  = mem_valid ? wq[idx] : rand_word();
      #1;
      if (lit_chk) begin
        check("lit_latency_valid", valid_out, 1);
        check("lit_latency_data", data_out, lit_val);
        lit_chk = 0;
      end
      if (prev_stall) begin
        check("stall_valid", valid_out, 1);
        check("stall_data", data_out, prev_data);
      end
      if (rep_first || rep_guard > 0) check("rep_mem_ready", mem_ready, 0);
      rep_first = 0;
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", valid_out, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", data_out, e.data);
          if (e.id == cur_rep && rep_guard > 0) rep_guard--;
        end
        m_count++;
        dep++;
      end
      if (mem_valid && mem_ready) begin
        model_accept(wq[idx]);
        idx++;
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
      idle = valid_out ? 0 : idle + 1;
      cyc++;
      if (stop_at >= 0) done = (dep >= stop_at);
      else done = (idx == wq.size()) && (exp_q.size() == 0) && (idle >= 3);
    end
    if (!done) check("stream_timeout", DW'(wq.size() - idx + exp_q.size()), 0);
    if (stop_at < 0) begin
      check("err", err, m_err);
      check("out_count", out_count, m_count);
    end
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    mem_valid = 1'b0;
    ready_out = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    rep_seq = 0;
    cur_rep = 0;

    // Reset state with the memory side idle
    apply_reset();
    @(negedge clock);
    #1;
    check("reset_mem_ready", mem_ready, 1);
    check("reset_valid_out", valid_out, 0);
    check("reset_data_out", data_out, 0);
    check("reset_out_count", out_count, 0);
    check("reset_err", err, 0);

    // Single literal
    wq.delete();
    wq.push_back(hdr(2'b00, $urandom));
    wq.push_back(48'h0000_1234_5678);
    run_stream(100, -1, 200);
    check("single_count", out_count, 1);

    // Literal plus REPEAT 3 with ready held high
    apply_reset();
    a = rand_word();
    wq.delete();
    wq.push_back(hdr(2'b00, $urandom));
    wq.push_back(a);
    wq.push_back(hdr(2'b01, 3));
    run_stream(100, -1, 200);
    check("rep3_count", out_count, 4);
    check("rep3_back_in_hdr", mem_ready, 1);

    // Same stream with downstream stalls
    apply_reset();
    a = rand_word();
    wq.delete();
    wq.push_back(hdr(2'b00, $urandom));
    wq.push_back(a);
    wq.push_back(hdr(2'b01, 3));
    run_stream(-1, -1, 300);
    check("rep3_stall_count", out_count, 4);

    // Early REPEAT, reserved tag, then a normal literal
    apply_reset();
    wq.delete();
    wq.push_back(hdr(2'b01, 2));
    run_stream(100, -1, 100);
    check("early_rep_err", err, 1);
    check("early_rep_no_out", out_count, 0);
    wq.delete();
    wq.push_back(hdr(2'b11, $urandom));
    run_stream(100, -1, 100);
    check("rsv_err_sticky", err, 1);
    b = rand_word();
    wq.delete();
    wq.push_back(hdr(2'b00, $urandom));
    wq.push_back(b);
    run_stream(100, -1, 100);
    check("after_err_count", out_count, 1);

    // Reset in the middle of a long repeat
    apply_reset();
    a = rand_word();
    wq.delete();
    wq.push_back(hdr(2'b00, $urandom));
    wq.push_back(a);
    wq.push_back(hdr(2'b01, 100));
    run_stream(100, 61, 500);
    reset_n = 1'b0;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_mem_ready", mem_ready, 1);
    check("midrst_out_count", out_count, 0);
    check("midrst_data_out", data_out, 0);
    mem_valid = 1'b0;
    ready_out = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wq.delete();
    wq.push_back(hdr(2'b01, 1));
    run_stream(100, -1, 100);
    check("midrst_have_lit_cleared", err, 1);

    // Randomized streams under varying backpressure
    for (int r = 0; r < 6; r++) begin
      int pct;
      apply_reset();
      pct = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 75 : 40);
      wq.delete();
      wq.push_back(hdr(2'b00, $urandom));
      wq.push_back(rand_word());
      for (int k = 0; k < 20; k++) begin
        int kind;
        kind = int'($urandom_range(9));
        if (kind <= 4 || kind == 9) begin
          wq.push_back(hdr(2'b00, $urandom));
          wq.push_back(rand_word());
        end else if (kind <= 7) begin
          wq.push_back(hdr(2'b01, $urandom_range(4)));
        end else begin
          wq.push_back(hdr(2'($urandom_range(3, 2)), $urandom));
        end
      end
      run_stream(pct, -1, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
